tpu_systolic_array: RTL and testbench

- 4x4 weight-stationary systolic matrix-multiply unit (MMU) for the brightness-filter datapath.
- Each processing element (PE) holds one weight, forwards input data to the right, and passes partial sums down.
- Bottom-row partial sums are the column results (dot products).
- Weights are shifted in from the top while `control`=1; computation runs while `control`=0.

---
 rtl/tpu_pkg.sv | 11 +
 rtl/tpu_systolic_array_pe.sv | 74 +++++++
 rtl/tpu_systolic_array.sv | 73 +++++++
 tb/tb_tpu_systolic_array.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and element types for the 4x4 weight-stationary systolic array.
package tpu_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int ACC_WIDTH = 40;
  localparam int DEPTH     = 4;

  typedef logic [BIT_WIDTH-1:0] data_t;
  typedef logic [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/tpu_systolic_array_pe.sv
// One weight-stationary processing element: shifting weight register, data pass-through, MAC.
// Optional macro TPU_SATURATE_EN makes the accumulation saturate instead of wrapping.
module tpu_pe
  import tpu_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int acc_width = ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 control,
  input  logic [bit_width-1:0] wt_in,
  input  logic [bit_width-1:0] data_in,
  input  logic [acc_width-1:0] psum_in,
  output logic [bit_width-1:0] wt_out,
  output logic [bit_width-1:0] data_out,
  output logic [acc_width-1:0] psum_out
);

  localparam int PROD_WIDTH = 2 * bit_width;

  logic [bit_width-1:0]  wt_q, wt_d;
  logic [bit_width-1:0]  data_q, data_d;
  logic [acc_width-1:0]  psum_q, psum_d;
  logic [PROD_WIDTH-1:0] prod;
  logic [acc_width-1:0]  prod_ext;
  logic [acc_width-1:0]  mac_sum;
`ifdef TPU_SATURATE_EN
  logic [acc_width:0]    sum_ext;
`endif

  // Unsigned product is zero-extended before accumulation; it can never overflow itself.
  always_comb begin
    prod     = PROD_WIDTH'(data_in) * PROD_WIDTH'(wt_q);
    prod_ext = acc_width'(prod);
`ifdef TPU_SATURATE_EN
    sum_ext  = {1'b0, psum_in} + {1'b0, prod_ext};
    mac_sum  = sum_ext[acc_width] ? '1 : sum_ext[acc_width-1:0];
`else
    mac_sum  = psum_in + prod_ext;
`endif
  end

  always_comb begin
    wt_d   = wt_q;
    data_d = data_q;
    psum_d = psum_q;
    if (control) begin
      wt_d   = wt_in;
      data_d = '0;
      psum_d = '0;
    end else begin
      data_d = data_in;
      psum_d = mac_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_q   <= '0;
      data_q <= '0;
      psum_q <= '0;
    end else begin
      wt_q   <= wt_d;
      data_q <= data_d;
      psum_q <= psum_d;
    end
  end

  assign wt_out   = wt_q;
  assign data_out = data_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/tpu_systolic_array.sv
// 4x4 weight-stationary systolic matrix-multiply unit: weights shift down, data moves right,
// partial sums move down. Macro TPU_SATURATE_EN (in tpu_pe) selects saturating accumulation.
module tpu_systolic_array
  import tpu_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int acc_width = ACC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       control,
  input  logic [bit_width*DEPTH-1:0] data_arr,
  input  logic [bit_width*DEPTH-1:0] wt_arr,
  output logic [acc_width*DEPTH-1:0] acc_out,
  output logic [acc_width-1:0]       pe30_out,
  output logic [acc_width-1:0]       pe31_out,
  output logic [acc_width-1:0]       pe32_out,
  output logic [acc_width-1:0]       pe33_out
);

  // Grid-wide views of every PE register, kept at this level for hierarchical probing.
  logic [bit_width-1:0] wt_out   [DEPTH][DEPTH];
  logic [bit_width-1:0] data_out [DEPTH][DEPTH];
  logic [acc_width-1:0] psum     [DEPTH][DEPTH];

  logic [bit_width-1:0] wt_in    [DEPTH][DEPTH];
  logic [bit_width-1:0] data_in  [DEPTH][DEPTH];
  logic [acc_width-1:0] psum_in  [DEPTH][DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    for (genvar j = 0; j < DEPTH; j++) begin : g_col
      // Edge PEs take external inputs; interior PEs chain off their neighbours.
      if (i == 0) begin : g_top
        assign wt_in[i][j]   = wt_arr[bit_width*j +: bit_width];
        assign psum_in[i][j] = '0;
      end else begin : g_inner_row
        assign wt_in[i][j]   = wt_out[i-1][j];
        assign psum_in[i][j] = psum[i-1][j];
      end

      if (j == 0) begin : g_left
        assign data_in[i][j] = data_arr[bit_width*i +: bit_width];
      end else begin : g_inner_col
        assign data_in[i][j] = data_out[i][j-1];
      end

      tpu_pe #(
        .bit_width (bit_width),
        .acc_width (acc_width)
      ) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .control  (control),
        .wt_in    (wt_in[i][j]),
        .data_in  (data_in[i][j]),
        .psum_in  (psum_in[i][j]),
        .wt_out   (wt_out[i][j]),
        .data_out (data_out[i][j]),
        .psum_out (psum[i][j])
      );
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_acc
    assign acc_out[acc_width*j +: acc_width] = psum[DEPTH-1][j];
  end

  assign pe30_out = psum[DEPTH-1][0];
  assign pe31_out = psum[DEPTH-1][1];
  assign pe32_out = psum[DEPTH-1][2];
  assign pe33_out = psum[DEPTH-1][3];

endmodule

// File: tb/tb_tpu_systolic_array.sv
// Self-checking bench for tpu_systolic_array against a dot-product reference model.
module tb_tpu_systolic_array;

  localparam int BW   = 16;
  localparam int AW   = 40;
  localparam int N    = 4;
  localparam int HIST = 1024;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          control  = 1'b0;
  logic [BW*N-1:0] data_arr = '0;
  logic [BW*N-1:0] wt_arr   = '0;
  logic [AW*N-1:0] acc_out;
  logic [AW-1:0]   pe30_out, pe31_out, pe32_out, pe33_out;
  logic [32*N-1:0] acc32;
  logic [31:0]     p32_0, p32_1, p32_2, p32_3;
  logic [AW-1:0]   pe_out [N];
  logic [31:0]     p32 [N];

  int errors = 0;
  int checks = 0;

  // Reference model state: history of row inputs per clock edge, weight matrix, last flush edge.
  int          edge_n     = 0;
  int          last_flush = -1;
  logic [15:0] hist  [HIST][N];
  logic [15:0] wm    [N][N];
  logic [15:0] wload [N][N];
  logic [63:0] vecs  [$];

  always #5 clk = ~clk;

  tpu_systolic_array dut (
    .clk(clk), .rst_n(rst_n), .control(control), .data_arr(data_arr), .wt_arr(wt_arr),
    .acc_out(acc_out), .pe30_out(pe30_out), .pe31_out(pe31_out), .pe32_out(pe32_out),
    .pe33_out(pe33_out)
  );

  tpu_systolic_array #(.acc_width(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .control(control), .data_arr(data_arr), .wt_arr(wt_arr),
    .acc_out(acc32), .pe30_out(p32_0), .pe31_out(p32_1), .pe32_out(p32_2), .pe33_out(p32_3)
  );

  assign pe_out[0] = pe30_out;
  assign pe_out[1] = pe31_out;
  assign pe_out[2] = pe32_out;
  assign pe_out[3] = pe33_out;
  assign p32[0] = p32_0;
  assign p32[1] = p32_1;
  assign p32[2] = p32_2;
  assign p32[3] = p32_3;

  // Drive one cycle of inputs, advance one rising edge, update the model, settle 1 time unit.
  task automatic step(input logic ctl, input logic [63:0] dv, input logic [63:0] wv);
    control  = ctl;
    data_arr = dv;
    wt_arr   = wv;
    @(posedge clk);
    if (edge_n >= HIST) begin
      $display("[TB] FAIL history_overflow got %0d edges limit %0d", edge_n, HIST);
      $fatal(1);
    end
    for (int i = 0; i < N; i++) hist[edge_n][i] = dv[16*i +: 16];
    if (ctl) begin
      for (int i = N-1; i > 0; i--)
        for (int j = 0; j < N; j++) wm[i][j] = wm[i-1][j];
      for (int j = 0; j < N; j++) wm[0][j] = wv[16*j +: 16];
      last_flush = edge_n;
    end
    edge_n++;
    #1;
  endtask

  // Column j after the latest edge e: sum of row-i data that entered at e-(3-i)-j times W[i][j],
  // counting only data whose whole trip through the array happened in compute mode.
  function automatic logic [AW-1:0] model_out(int j);
    logic [63:0] s;
    int e, k;
    s = 64'd0;
    e = edge_n - 1;
    for (int i = 0; i < N; i++) begin
      k = e - (N-1-i) - j;
      if (k > last_flush && k >= 0) s = s + 64'(hist[k][i]) * 64'(wm[i][j]);
    end
    return s[AW-1:0];
  endfunction

  // Row i at cycle c carries element i of the vector that started at cycle c-i.
  function automatic logic [63:0] skew_data(int c);
    logic [63:0] r;
    int v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      v = c - i;
      if (v >= 0 && v < vecs.size()) r[16*i +: 16] = vecs[v][16*i +: 16];
    end
    return r;
  endfunction

  task automatic load_weights();
    logic [63:0] wv;
    for (int r = N-1; r >= 0; r--) begin
      for (int j = 0; j < N; j++) wv[16*j +: 16] = wload[r][j];
      step(1'b1, $urandom, wv);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    control  = 1'($urandom);
    data_arr = {$urandom, $urandom};
    wt_arr   = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) begin
      checks++;
      if (pe_out[j] !== '0 || acc_out[AW*j +: AW] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_out col%0d got %h/%h want 0", j, pe_out[j], acc_out[AW*j +: AW]);
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (dut.wt_out[i][j] !== 16'h0) begin
          errors++;
          $display("[TB] FAIL reset_wt(%0d,%0d) got %h want 0", i, j, dut.wt_out[i][j]);
        end
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wm[i][j] = '0;
    last_flush = edge_n - 1;
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    logic [AW-1:0] exp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wload[i][j] = (i == j) ? 16'd1 : 16'd0;
    load_weights();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (dut.wt_out[i][j] !== wload[i][j]) begin
          errors++;
          $display("[TB] FAIL identity_wt(%0d,%0d) got %h want %h", i, j, dut.wt_out[i][j], wload[i][j]);
        end
      end
    vecs.delete();
    vecs.push_back(64'h0004_0003_0002_0001);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, skew_data(c), '0);
      for (int j = 0; j < N; j++) begin
        exp = model_out(j);
        if (c == 3 + j) exp = AW'(j + 1);
        checks++;
        if (pe_out[j] !== exp || acc_out[AW*j +: AW] !== exp) begin
          errors++;
          $display("[TB] FAIL identity col%0d t+%0d got %h want %h", j, c, pe_out[j], exp);
        end
      end
    end
  endtask

  task automatic test_all_twos();
    logic [AW-1:0] exp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wload[i][j] = 16'd2;
    load_weights();
    vecs.delete();
    vecs.push_back(64'h0004_0003_0002_0001);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, skew_data(c), '0);
      for (int j = 0; j < N; j++) begin
        exp = (c == 3 + j) ? AW'(20) : AW'(0);
        checks++;
        if (pe_out[j] !== exp || model_out(j) !== exp) begin
          errors++;
          $display("[TB] FAIL twos col%0d t+%0d got %h model %h want %h", j, c, pe_out[j], model_out(j), exp);
        end
      end
    end
  endtask

  task automatic test_max();
    logic [AW-1:0] exp;
    logic [31:0]   exp32;
`ifdef TPU_SATURATE_EN
    exp32 = 32'hFFFF_FFFF;
`else
    exp32 = 32'hFFF8_0004;
`endif
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wload[i][j] = 16'hFFFF;
    load_weights();
    vecs.delete();
    vecs.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, skew_data(c), '0);
      for (int j = 0; j < N; j++) begin
        exp = model_out(j);
        if (c == 3 + j) exp = 40'h3_FFF8_0004;
        checks++;
        if (pe_out[j] !== exp) begin
          errors++;
          $display("[TB] FAIL max col%0d t+%0d got %h want %h", j, c, pe_out[j], exp);
        end
        if (c == 3 + j) begin
          checks++;
          if (p32[j] !== exp32 || acc32[32*j +: 32] !== exp32) begin
            errors++;
            $display("[TB] FAIL max_acc32 col%0d got %h want %h", j, p32[j], exp32);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wload[i][j] = (i == 0) ? 16'd1 : (i == 3) ? 16'd3 : 16'd0;
    load_weights();
    vecs.delete();
    vecs.push_back(64'h0000_0000_0000_0001);
    vecs.push_back(64'h0005_0000_0000_0000);
    for (int c = 0; c < 11; c++) begin
      step(1'b0, skew_data(c), '0);
      for (int j = 0; j < N; j++) begin
        exp = (c == 3 + j) ? AW'(1) : (c == 4 + j) ? AW'(15) : AW'(0);
        checks++;
        if (pe_out[j] !== exp || model_out(j) !== exp) begin
          errors++;
          $display("[TB] FAIL b2b col%0d t+%0d got %h model %h want %h", j, c, pe_out[j], model_out(j), exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wload[i][j] = 16'($urandom);
    load_weights();
    vecs.delete();
    for (int v = 0; v < 12; v++) vecs.push_back({$urandom, $urandom});
    for (int c = 0; c < 12 + 7; c++) begin
      step(1'b0, skew_data(c), '0);
      for (int j = 0; j < N; j++) begin
        exp = model_out(j);
        checks++;
        if (pe_out[j] !== exp || acc_out[AW*j +: AW] !== exp) begin
          errors++;
          $display("[TB] FAIL random col%0d t+%0d got %h want %h", j, c, pe_out[j], exp);
        end
      end
    end
  endtask

  task automatic test_flush_control();
    logic [63:0]   wrow;
    logic [15:0]   want;
    logic [AW-1:0] exp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wload[i][j] = 16'($urandom_range(1, 65535));
    load_weights();
    vecs.delete();
    vecs.push_back({$urandom, $urandom});
    vecs.push_back({$urandom, $urandom});
    for (int c = 0; c < 4; c++) step(1'b0, skew_data(c), '0);
    wrow = {$urandom, $urandom};
    step(1'b1, skew_data(4), wrow);
    for (int j = 0; j < N; j++) begin
      checks++;
      if (pe_out[j] !== '0 || model_out(j) !== '0) begin
        errors++;
        $display("[TB] FAIL ctl_flush col%0d got %h want 0", j, pe_out[j]);
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        want = (i == 0) ? wrow[16*j +: 16] : wload[i-1][j];
        checks++;
        if (dut.wt_out[i][j] !== want) begin
          errors++;
          $display("[TB] FAIL ctl_shift_wt(%0d,%0d) got %h want %h", i, j, dut.wt_out[i][j], want);
        end
      end
    vecs.delete();
    vecs.push_back({$urandom, $urandom});
    for (int c = 0; c < 8; c++) begin
      step(1'b0, skew_data(c), '0);
      for (int j = 0; j < N; j++) begin
        exp = model_out(j);
        checks++;
        if (pe_out[j] !== exp) begin
          errors++;
          $display("[TB] FAIL ctl_after col%0d t+%0d got %h want %h", j, c, pe_out[j], exp);
        end
      end
    end
  endtask

  task automatic test_flush_reset();
    logic [AW-1:0] exp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wload[i][j] = 16'($urandom_range(1, 65535));
    load_weights();
    vecs.delete();
    vecs.push_back({$urandom, $urandom});
    for (int c = 0; c < 4; c++) step(1'b0, skew_data(c), '0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < N; j++) begin
      checks++;
      if (pe_out[j] !== '0 || acc_out[AW*j +: AW] !== '0) begin
        errors++;
        $display("[TB] FAIL rst_flush col%0d got %h want 0", j, pe_out[j]);
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (dut.wt_out[i][j] !== 16'h0) begin
          errors++;
          $display("[TB] FAIL rst_flush_wt(%0d,%0d) got %h want 0", i, j, dut.wt_out[i][j]);
        end
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wm[i][j] = '0;
    last_flush = edge_n - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vecs.delete();
    vecs.push_back({$urandom, $urandom});
    for (int c = 0; c < 8; c++) begin
      step(1'b0, skew_data(c), '0);
      for (int j = 0; j < N; j++) begin
        exp = model_out(j);
        checks++;
        if (pe_out[j] !== exp) begin
          errors++;
          $display("[TB] FAIL rst_after col%0d t+%0d got %h want %h", j, c, pe_out[j], exp);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_all_twos();
    test_max();
    test_back_to_back();
    test_random();
    test_flush_control();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
